// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle: inputs from the ID/EX stages and data memory, and the
// advance/flush controls plus status and event counters returned to the pipeline.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic             ex_mem_read;
    logic [4:0]       ex_rd;
    logic             ex_branch_taken;
    logic             dmem_busy;
    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output ex_mem_read, ex_rd, ex_branch_taken, dmem_busy,
        input  pc_en, ifid_en, idex_en, ifid_flush, idex_flush,
        input  state, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  ex_mem_read, ex_rd, ex_branch_taken, dmem_busy,
        output pc_en, ifid_en, idex_en, ifid_flush, idex_flush,
        output state, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: freezes on data-memory busy, flushes on taken
// branches, inserts a single bubble on load-use, and counts stall/flush events.
module pipe_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    pipe_hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {
        RUN       = 2'd0,
        MEM_WAIT  = 2'd1,
        LU_BUBBLE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             lu;
    logic             rs1_hit;
    logic             rs2_hit;
    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             flush_evt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // The bubble cycle re-sees the same ID instruction, so the hazard is masked there.
    always_comb begin
        rs1_hit = hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd);
        rs2_hit = hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd);
        lu      = hz.ex_mem_read && (hz.ex_rd != 5'd0) && (rs1_hit || rs2_hit)
                  && (state_q != LU_BUBBLE);
    end

    always_comb begin
        state_d    = state_q;
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_en    = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        flush_evt  = 1'b0;
        if (!reset) begin
            state_d = RUN;
        end else if (hz.dmem_busy) begin
            state_d = MEM_WAIT;
        end else if (hz.ex_branch_taken) begin
            pc_en      = 1'b1;
            ifid_en    = 1'b1;
            idex_en    = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            flush_evt  = 1'b1;
            state_d    = RUN;
        end else if (lu) begin
            idex_en    = 1'b1;
            idex_flush = 1'b1;
            state_d    = (state_q == RUN) ? LU_BUBBLE : RUN;
        end else begin
            pc_en   = 1'b1;
            ifid_en = 1'b1;
            idex_en = 1'b1;
            state_d = RUN;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= RUN;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (!pc_en) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
            if (flush_evt) begin
                flush_cnt <= sat_inc(flush_cnt);
            end
        end
    end

    assign hz.pc_en      = pc_en;
    assign hz.ifid_en    = ifid_en;
    assign hz.idex_en    = idex_en;
    assign hz.ifid_flush = ifid_flush;
    assign hz.idex_flush = idex_flush;
    assign hz.state      = state_q;
    assign hz.stall_cnt  = stall_cnt;
    assign hz.flush_cnt  = flush_cnt;
endmodule
